// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit beside the ALU; owns the architectural HI/LO registers.
// One result bit per cycle for MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, combinational MFHI/MFLO.
module alu_muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic [3:0]   alu_op,
    input  logic [5:0]   funct,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         flush,
    output logic         busy,
    output logic         stall,
    output logic [W-1:0] rd_val,
    output logic         done,
    output logic         div_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opb;
    logic           is_div;
    logic           dz;
    logic           neg_q;
    logic           neg_r;

    logic           r_type;
    logic           hit_md;
    logic           hit_hl;
    logic           op_signed;
    logic           rs_neg;
    logic           rt_neg;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;

    assign r_type    = req_valid & alu_op[3];
    assign hit_md    = r_type & (funct[5:2] == 4'b0110);
    assign hit_hl    = r_type & (funct[5:2] == 4'b0100);
    assign stall     = (hit_md | hit_hl) & busy;
    assign op_signed = ~funct[0];
    assign rs_neg    = op_signed & rs_val[W-1];
    assign rt_neg    = op_signed & rt_val[W-1];
    assign abs_a     = rs_neg ? -rs_val : rs_val;
    assign abs_b     = rt_neg ? -rt_val : rt_val;

    always_comb begin
        rd_val = '0;
        if (hit_hl && !busy && !funct[0])
            rd_val = funct[1] ? lo : hi;
    end

    // acc is {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_trial;
    logic [2*W-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_trial = div_shift - {1'b0, opb};
        if (!is_div)
            acc_step = {mul_sum, acc[W-1:1]};
        else if (div_trial[W])
            acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        else
            acc_step = {div_trial[W-1:0], acc[W-2:0], 1'b1};
    end

    logic [W-1:0] fix_hi;
    logic [W-1:0] fix_lo;

    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (dz) begin
            fix_hi = acc[W-1:0];
            fix_lo = '1;
        end else if (is_div) begin
            fix_lo = neg_q ? -acc[W-1:0] : acc[W-1:0];
            fix_hi = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        end else begin
            {fix_hi, fix_lo} = neg_q ? -acc : acc;
        end
    end

    // A zero divisor skips RUN entirely; the raw dividend rides in acc to become HI
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit_md) begin
                            busy   <= 1'b1;
                            is_div <= funct[1];
                            neg_q  <= rs_neg ^ rt_neg;
                            neg_r  <= rs_neg;
                            opb    <= abs_b;
                            if (funct[1] && rt_val == '0) begin
                                state <= FIX;
                                dz    <= 1'b1;
                                acc   <= {{W{1'b0}}, rs_val};
                            end else begin
                                state <= RUN;
                                dz    <= 1'b0;
                                cnt   <= CNT_W'(W - 1);
                                acc   <= {{W{1'b0}}, abs_a};
                            end
                        end else if (hit_hl && funct[0]) begin
                            if (funct[1])
                                lo <= rs_val;
                            else
                                hi <= rs_val;
                        end
                    end
                    RUN: begin
                        acc <= acc_step;
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    FIX: begin
                        hi       <= fix_hi;
                        lo       <= fix_lo;
                        done     <= 1'b1;
                        div_zero <= dz;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
